// File: rtl/kf8237_dma_port_pkg.sv
// Shared types for the KF8237 device-side DMA port: handshake FSM states and
// transfer direction encodings.
package kf8237_dma_port_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRequest,
        StActive,
        StRelease,
        StDone
    } state_e;

    localparam logic DIR_DEV_TO_MEM = 1'b0;
    localparam logic DIR_MEM_TO_DEV = 1'b1;

endpackage

// File: rtl/kf8237_dma_port_fifo.sv
// Byte FIFO with first-word-fall-through head; push to full (without a
// simultaneous pop) and pop from empty are dropped.
module kf8237_dma_port_fifo #(
    parameter int unsigned FIFO_AW = 4
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic             i_push,
    input  logic [7:0]       i_push_data,
    input  logic             i_pop,
    output logic [7:0]       o_head,
    output logic             o_full,
    output logic             o_empty,
    output logic [FIFO_AW:0] o_level,
    output logic [FIFO_AW:0] o_level_next
);

    localparam int unsigned DEPTH = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH_LVL = (FIFO_AW + 1)'(DEPTH);

    logic [7:0]         r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wptr;
    logic [FIFO_AW-1:0] r_rptr;
    logic [FIFO_AW:0]   r_level;
    logic               w_push_ok;
    logic               w_pop_ok;

    assign o_full    = (r_level == DEPTH_LVL);
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign o_head    = r_mem[r_rptr];
    assign w_pop_ok  = i_pop & ~o_empty;
    // A pop in the same cycle frees the slot a full-FIFO push needs.
    assign w_push_ok = i_push & (~o_full | w_pop_ok);

    always_comb begin
        o_level_next = r_level;
        if (w_push_ok && !w_pop_ok) begin
            o_level_next = r_level + (FIFO_AW + 1)'(1);
        end else if (!w_push_ok && w_pop_ok) begin
            o_level_next = r_level - (FIFO_AW + 1)'(1);
        end
    end

    always_ff @(posedge i_clock) begin
        if (w_push_ok) begin
            r_mem[r_wptr] <= i_push_data;
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + FIFO_AW'(1);
            end
            if (w_pop_ok) begin
                r_rptr <= r_rptr + FIFO_AW'(1);
            end
            r_level <= o_level_next;
        end
    end

endmodule

// File: rtl/kf8237_dma_device_port.sv
// Peripheral endpoint of an 8237 DMA channel: buffers device bytes, raises DREQ,
// and moves one byte per qualified IOR/IOW strobe while DACK is held.
module kf8237_dma_device_port
    import kf8237_dma_port_pkg::*;
#(
    parameter int unsigned FIFO_AW        = 4,
    parameter bit          DEMAND_DEFAULT = 1'b0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             direction,
    input  logic             demand_mode,
    input  logic             src_valid,
    input  logic [7:0]       src_data,
    output logic             src_ready,
    output logic             sink_valid,
    output logic [7:0]       sink_data,
    input  logic             sink_ready,
    output logic             dma_request,
    input  logic             dma_acknowledge,
    input  logic             io_read_n_in,
    input  logic             io_write_n_in,
    input  logic [7:0]       data_bus_in,
    output logic [7:0]       data_bus_out,
    output logic             data_bus_oe,
    input  logic             end_of_process_n_in,
    input  logic             clear_terminal_count,
    output logic             terminal_count,
    output logic [FIFO_AW:0] fifo_level
);

    localparam logic [FIFO_AW:0] DEPTH_LVL = (FIFO_AW + 1)'(2 ** FIFO_AW);

    state_e           r_state;
    logic             r_dreq;
    logic             r_tc;
    logic             r_dir;
    logic             r_mode;
    logic [7:0]       r_wr_hold;
    logic             r_dack_s1, r_dack_s2;
    logic             r_ior_s1, r_ior_s2;
    logic             r_iow_s1, r_iow_s2;
    logic             r_eop_s1, r_eop_s2;

    logic             w_dir_in;
    logic             w_ior_done;
    logic             w_iow_done;
    logic             w_xfer;
    logic             w_dev_push;
    logic             w_dev_pop;
    logic             w_fifo_push;
    logic             w_fifo_pop;
    logic [7:0]       w_fifo_wdata;
    logic [7:0]       w_head;
    logic             w_full;
    logic             w_empty;
    logic [FIFO_AW:0] w_level;
    logic [FIFO_AW:0] w_level_next;
    logic             w_cond;
    logic             w_cond_next;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_dack_s1 <= 1'b0;
            r_dack_s2 <= 1'b0;
            r_ior_s1  <= 1'b1;
            r_ior_s2  <= 1'b1;
            r_iow_s1  <= 1'b1;
            r_iow_s2  <= 1'b1;
            r_eop_s1  <= 1'b1;
            r_eop_s2  <= 1'b1;
        end else begin
            r_dack_s1 <= dma_acknowledge;
            r_dack_s2 <= r_dack_s1;
            r_ior_s1  <= io_read_n_in;
            r_ior_s2  <= r_ior_s1;
            r_iow_s1  <= io_write_n_in;
            r_iow_s2  <= r_iow_s1;
            r_eop_s1  <= end_of_process_n_in;
            r_eop_s2  <= r_eop_s1;
        end
    end

    // Completion is the trailing (rising) edge of the strobe, seen after sync.
    assign w_dir_in   = (r_dir == DIR_DEV_TO_MEM);
    assign w_ior_done = r_ior_s1 & ~r_ior_s2 & r_dack_s2 & w_dir_in;
    assign w_iow_done = r_iow_s1 & ~r_iow_s2 & r_dack_s2 & ~w_dir_in;
    assign w_xfer     = w_ior_done | w_iow_done;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_wr_hold <= 8'h00;
        end else if (r_dack_s2 && !r_iow_s2) begin
            r_wr_hold <= data_bus_in;
        end
    end

    assign src_ready    = ~w_full & w_dir_in;
    assign sink_valid   = ~w_empty & ~w_dir_in;
    assign sink_data    = w_head;
    assign w_dev_push   = src_valid & src_ready;
    assign w_dev_pop    = sink_valid & sink_ready;
    assign w_fifo_push  = w_dev_push | w_iow_done;
    assign w_fifo_pop   = w_dev_pop | w_ior_done;
    assign w_fifo_wdata = w_dir_in ? src_data : r_wr_hold;

    kf8237_dma_port_fifo #(
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .i_clock      (clock),
        .i_reset_n    (reset_n),
        .i_push       (w_fifo_push),
        .i_push_data  (w_fifo_wdata),
        .i_pop        (w_fifo_pop),
        .o_head       (w_head),
        .o_full       (w_full),
        .o_empty      (w_empty),
        .o_level      (w_level),
        .o_level_next (w_level_next)
    );

    assign w_cond      = w_dir_in ? ~w_empty : ~w_full;
    assign w_cond_next = w_dir_in ? (w_level_next != '0) : (w_level_next != DEPTH_LVL);

    // Output enable follows the raw pins so the bus sees data within the IOR pulse.
    assign data_bus_oe    = dma_acknowledge & ~io_read_n_in & w_dir_in;
    assign data_bus_out   = w_empty ? 8'h00 : w_head;
    assign dma_request    = r_dreq;
    assign terminal_count = r_tc;
    assign fifo_level     = w_level;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= StIdle;
            r_dreq  <= 1'b0;
            r_tc    <= 1'b0;
            r_dir   <= DIR_DEV_TO_MEM;
            r_mode  <= DEMAND_DEFAULT;
        end else begin
            if (clear_terminal_count) begin
                r_tc <= 1'b0;
            end
            unique case (r_state)
                StIdle: begin
                    r_dir  <= direction;
                    r_mode <= demand_mode;
                    if (enable && w_cond && !r_tc) begin
                        r_state <= StRequest;
                        r_dreq  <= 1'b1;
                    end
                end
                StRequest: begin
                    if (r_dack_s2) begin
                        r_state <= StActive;
                    end else if (!enable) begin
                        r_state <= StIdle;
                        r_dreq  <= 1'b0;
                    end
                end
                StActive: begin
                    if (r_dack_s2 && !r_eop_s2) begin
                        r_state <= StDone;
                        r_dreq  <= 1'b0;
                        r_tc    <= 1'b1;
                    end else if (w_xfer) begin
                        if (!(r_mode && w_cond_next)) begin
                            r_state <= StRelease;
                            r_dreq  <= 1'b0;
                        end
                    end else if (!r_dack_s2) begin
                        // Bus preempted mid-block: re-arbitrate if work remains.
                        if (w_cond) begin
                            r_state <= StRequest;
                        end else begin
                            r_state <= StRelease;
                            r_dreq  <= 1'b0;
                        end
                    end
                end
                StRelease: begin
                    if (!r_dack_s2) begin
                        r_state <= StIdle;
                    end
                end
                StDone: begin
                    if (!r_dack_s2 && (clear_terminal_count || !enable)) begin
                        r_state <= StIdle;
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_dreq  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_kf8237_dma_device_port.sv
// Scoreboard bench: stimulus queues expected bytes, a monitor checks them as
// the port presents them on IOR cycles or the sink interface.
module tb_kf8237_dma_device_port;

    localparam int unsigned AW    = 2;
    localparam int unsigned DEPTH = 4;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic enable = 1'b0;
    logic direction = 1'b0;
    logic demand_mode = 1'b0;
    logic src_valid = 1'b0;
    logic [7:0] src_data = 8'h00;
    logic src_ready;
    logic sink_valid;
    logic [7:0] sink_data;
    logic sink_ready = 1'b0;
    logic dma_request;
    logic dma_acknowledge = 1'b0;
    logic io_read_n_in = 1'b1;
    logic io_write_n_in = 1'b1;
    logic [7:0] data_bus_in = 8'h00;
    logic [7:0] data_bus_out;
    logic data_bus_oe;
    logic end_of_process_n_in = 1'b1;
    logic clear_terminal_count = 1'b0;
    logic terminal_count;
    logic [AW:0] fifo_level;

    int checks = 0;
    int failures = 0;
    int m_level = 0;
    logic [7:0] exp_q[$];
    logic prev_oe = 1'b0;

    kf8237_dma_device_port #(
        .FIFO_AW        (AW),
        .DEMAND_DEFAULT (1'b0)
    ) dut (
        .clock                (clock),
        .reset_n              (reset_n),
        .enable               (enable),
        .direction            (direction),
        .demand_mode          (demand_mode),
        .src_valid            (src_valid),
        .src_data             (src_data),
        .src_ready            (src_ready),
        .sink_valid           (sink_valid),
        .sink_data            (sink_data),
        .sink_ready           (sink_ready),
        .dma_request          (dma_request),
        .dma_acknowledge      (dma_acknowledge),
        .io_read_n_in         (io_read_n_in),
        .io_write_n_in        (io_write_n_in),
        .data_bus_in          (data_bus_in),
        .data_bus_out         (data_bus_out),
        .data_bus_oe          (data_bus_oe),
        .end_of_process_n_in  (end_of_process_n_in),
        .clear_terminal_count (clear_terminal_count),
        .terminal_count       (terminal_count),
        .fifo_level           (fifo_level)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, act, req);
        end
    endtask

    task automatic compare_pop(input string name, input logic [7:0] act);
        logic [7:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s got=%0h expected=<nothing queued>", name, act);
        end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
                failures++;
                $display("FAIL %s got=%0h expected=%0h", name, act, e);
            end
        end
    endtask

    // Monitor: one byte per IOR pulse (first cycle of oe) and per sink handshake.
    always @(negedge clock) begin
        if (reset_n) begin
            if (data_bus_oe && !prev_oe) compare_pop("ior_data", data_bus_out);
            if (sink_valid && sink_ready) compare_pop("sink_data", sink_data);
        end
        prev_oe = data_bus_oe;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] d);
        check("src_ready", src_ready, (m_level < DEPTH) ? 1 : 0);
        src_valid = 1'b1;
        src_data  = d;
        if (m_level < DEPTH) begin
            exp_q.push_back(d);
            m_level++;
        end
        tick();
        src_valid = 1'b0;
    endtask

    task automatic wait_dreq(input string name);
        int n = 0;
        while (!dma_request && n < 30) begin
            tick();
            n++;
        end
        check(name, dma_request, 1);
    endtask

    task automatic bus_cycle(input bit is_read, input logic [7:0] d, input bit eop);
        dma_acknowledge = 1'b1;
        repeat (3) tick();
        if (is_read) io_read_n_in = 1'b0;
        else io_write_n_in = 1'b0;
        data_bus_in = d;
        if (eop) end_of_process_n_in = 1'b0;
        repeat (3) tick();
        io_read_n_in = 1'b1;
        io_write_n_in = 1'b1;
        end_of_process_n_in = 1'b1;
        repeat (3) tick();
    endtask

    task automatic drop_dack();
        dma_acknowledge = 1'b0;
        repeat (3) tick();
    endtask

    task automatic drain_sink();
        int n = 0;
        sink_ready = 1'b1;
        while (fifo_level != 0 && n < 20) begin
            tick();
            n++;
        end
        sink_ready = 1'b0;
        m_level = 0;
        check("drain_level", fifo_level, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        int n;

        repeat (3) tick();
        check("rst_dreq", dma_request, 0);
        check("rst_oe", data_bus_oe, 0);
        check("rst_dout", data_bus_out, 0);
        check("rst_tc", terminal_count, 0);
        check("rst_level", fifo_level, 0);
        reset_n = 1'b1;

        // Device-to-memory, single mode, fill to full then drain by IOR.
        enable = 1'b1;
        repeat (2) tick();
        for (int i = 0; i < 5; i++) push_byte(8'($urandom));
        check("a_level_full", fifo_level, DEPTH);
        for (int i = 0; i < 4; i++) begin
            wait_dreq("a_dreq");
            bus_cycle(1'b1, 8'h00, 1'b0);
            m_level--;
            check("a_dreq_release", dma_request, 0);
            check("a_level", fifo_level, m_level);
            drop_dack();
        end
        repeat (4) tick();
        check("a_idle_empty", dma_request, 0);

        // Memory-to-device, demand mode: four IOWs fill the FIFO.
        demand_mode = 1'b1;
        direction = 1'b1;
        wait_dreq("b_dreq");
        for (int i = 0; i < 4; i++) begin
            d = 8'($urandom);
            bus_cycle(1'b0, d, 1'b0);
            exp_q.push_back(d);
            m_level++;
            check("b_dreq_hold", dma_request, (i < 3) ? 1 : 0);
            check("b_level", fifo_level, m_level);
        end
        drop_dack();
        drain_sink();
        wait_dreq("b_rereq");

        // EOP during third IOW: terminal count, no re-request until cleared.
        for (int i = 0; i < 3; i++) begin
            d = 8'($urandom);
            bus_cycle(1'b0, d, (i == 2));
            exp_q.push_back(d);
            m_level++;
        end
        check("c_tc", terminal_count, 1);
        check("c_dreq", dma_request, 0);
        check("c_level", fifo_level, 3);
        drop_dack();
        repeat (6) tick();
        check("c_no_rereq", dma_request, 0);
        check("c_tc_sticky", terminal_count, 1);
        clear_terminal_count = 1'b1;
        tick();
        clear_terminal_count = 1'b0;
        check("c_tc_clear", terminal_count, 0);
        wait_dreq("c_rereq");
        drain_sink();

        // Ignored strobes: IOR without DACK, IOW while direction is dev->mem.
        enable = 1'b0;
        repeat (2) tick();
        check("d_dreq_off", dma_request, 0);
        direction = 1'b0;
        repeat (2) tick();
        push_byte(8'($urandom));
        push_byte(8'($urandom));
        io_read_n_in = 1'b0;
        repeat (2) tick();
        check("d_oe_nodack", data_bus_oe, 0);
        io_read_n_in = 1'b1;
        repeat (3) tick();
        check("d_level_ior", fifo_level, 2);
        enable = 1'b1;
        wait_dreq("d_dreq");
        bus_cycle(1'b0, 8'hEE, 1'b0);
        check("d_level_iow", fifo_level, 2);
        bus_cycle(1'b1, 8'h00, 1'b0);
        m_level--;
        check("d_demand_hold", dma_request, 1);

        // DACK withdrawn mid-block: back to REQUEST, DREQ stays high.
        dma_acknowledge = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("e_dreq_kept", dma_request, 1);
        end
        check("e_level", fifo_level, 1);
        bus_cycle(1'b1, 8'h00, 1'b0);
        m_level--;
        check("e_release", dma_request, 0);
        check("e_level_empty", fifo_level, 0);
        drop_dack();

        // Reset while ACTIVE with three bytes buffered.
        for (int i = 0; i < 3; i++) push_byte(8'($urandom));
        wait_dreq("f_dreq");
        dma_acknowledge = 1'b1;
        repeat (4) tick();
        reset_n = 1'b0;
        tick();
        check("f_dreq", dma_request, 0);
        check("f_level", fifo_level, 0);
        check("f_tc", terminal_count, 0);
        exp_q.delete();
        m_level = 0;
        dma_acknowledge = 1'b0;
        reset_n = 1'b1;
        repeat (5) tick();
        check("f_idle", dma_request, 0);

        // Random single-mode rounds.
        demand_mode = 1'b0;
        repeat (2) tick();
        for (int r = 0; r < 3; r++) begin
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) push_byte(8'($urandom));
            for (int i = 0; i < n; i++) begin
                wait_dreq("g_dreq");
                bus_cycle(1'b1, 8'h00, 1'b0);
                m_level--;
                check("g_release", dma_request, 0);
                drop_dack();
                repeat ($urandom_range(0, 3)) tick();
            end
            check("g_level", fifo_level, 0);
        end

        repeat (4) tick();
        check("exp_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
